// File: rtl/spinner_pkg.sv
// Shared types and helpers for the iterating spinner.
// SPINNER_DIR_EN adds a per-job rotate direction.
package spinner_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // source bit index feeding output bit i when rotating by a
  function automatic int rot_idx(
    input int i,
    input int a,
    input int w,
    input bit left
  );
    if (left)
      return (i - a + w) % w;
    else
      return (i + a) % w;
  endfunction

endpackage

// File: rtl/spinner_iter_if.sv
// Producer/consumer handshake bundle for spinner_iter.
// SPINNER_DIR_EN adds the in_left direction bit.
interface spinner_iter_if #(
  parameter int WIDTH = 8,
  parameter int RW    = 4
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amount;
  logic [RW-1:0]    in_rounds;
`ifdef SPINNER_DIR_EN
  logic             in_left;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_data, in_amount, in_rounds,
`ifdef SPINNER_DIR_EN
    output in_left,
`endif
    output out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_amount, in_rounds,
`ifdef SPINNER_DIR_EN
    input  in_left,
`endif
    input  out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/spinner_iter_barrel_rotator.sv
// Combinational log-shifter rotator, one mux stage per amount bit.
// SPINNER_DIR_EN adds a left-rotate select.
module barrel_rotator
  import spinner_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] x,
  input  logic [SHW-1:0]   amt,
`ifdef SPINNER_DIR_EN
  input  logic             left,
`endif
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] s [SHW+1];

  assign s[0] = x;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam int RI = rot_idx(i, 1 << k, WIDTH, 1'b0);
`ifdef SPINNER_DIR_EN
      localparam int LI = rot_idx(i, 1 << k, WIDTH, 1'b1);
      logic src;
      assign src = left ? s[k][LI] : s[k][RI];
`else
      logic src;
      assign src = s[k][RI];
`endif
      assign s[k+1][i] = amt[k] ? src : s[k][i];
    end
  end

  assign y = s[SHW];

endmodule

// File: rtl/spinner_iter.sv
// Iterating rotator: rotates a word by amount once per clock for R rounds.
// SPINNER_DIR_EN enables per-job left/right direction.
module spinner_iter
  import spinner_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  spinner_iter_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [SHW-1:0]   amt_q;
  logic [RW-1:0]    cnt_q;
  logic [WIDTH-1:0] rot;
  logic             load, step;
`ifdef SPINNER_DIR_EN
  logic             left_q;
`endif

  barrel_rotator #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_rot (
    .x   (data_q),
    .amt (amt_q),
`ifdef SPINNER_DIR_EN
    .left(left_q),
`endif
    .y   (rot)
  );

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    load          = 1'b0;
    step          = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = (bus.in_rounds == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        bus.busy = 1'b1;
        step     = 1'b1;
        if (cnt_q == RW'(1)) state_d = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_data = data_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      amt_q   <= '0;
      cnt_q   <= '0;
`ifdef SPINNER_DIR_EN
      left_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (load) begin
        data_q <= bus.in_data;
        amt_q  <= bus.in_amount;
        cnt_q  <= bus.in_rounds;
`ifdef SPINNER_DIR_EN
        left_q <= bus.in_left;
`endif
      end else if (step) begin
        data_q <= rot;
        cnt_q  <= cnt_q - RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_spinner_iter.sv
// Scoreboard bench for spinner_iter: expected results queued at drive time.
// Covers latency, identity runs, backpressure and mid-job reset.
module tb_spinner_iter;

  localparam int W  = 8;
  localparam int RW = 4;

  typedef struct {
    logic [W-1:0] data;
    int           rounds;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  spinner_iter_if #(.WIDTH(W), .RW(RW)) bus ();

  spinner_iter #(.WIDTH(W), .RW(RW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] x,
                                         input int a, input int r,
                                         input bit left);
    logic [W-1:0] v, y;
    v = x;
    for (int k = 0; k < r; k++) begin
      for (int i = 0; i < W; i++)
        y[i] = left ? v[(i - a + W) % W] : v[(i + a) % W];
      v = y;
    end
    return v;
  endfunction

  task automatic drive(input logic [W-1:0] d, input int a,
                       input int r, input bit left);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_amount = a[$clog2(W)-1:0];
    bus.in_rounds = r[RW-1:0];
`ifdef SPINNER_DIR_EN
    bus.in_left   = left;
`endif
  endtask

  task automatic push(input logic [W-1:0] d, input int a,
                      input int r, input bit left);
    exp_t e;
    e.data   = model(d, a, r, left);
    e.rounds = r;
    sb.push_back(e);
  endtask

  // called at the negedge right after the accept edge
  task automatic collect(input int hold, input bit poke);
    exp_t e;
    int   n;
    logic [W-1:0] held;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    n = 0;
    while (!bus.out_valid && n < 40) begin
      chk("busy", bus.busy, 1);
      chk("rdy_lo", bus.in_ready, 0);
      @(negedge clock);
      n++;
    end
    chk("latency", n, e.rounds);
    chk("data", bus.out_data, e.data);
    held = bus.out_data;
    if (poke) drive(8'h3C, 1, 0, 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_data", bus.out_data, held);
      chk("bp_rdy", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    chk("post_valid", bus.out_valid, 0);
    chk("post_rdy", bus.in_ready, 1);
  endtask

  task automatic send(input logic [W-1:0] d, input int a,
                      input int r, input bit left);
    chk("acc_rdy", bus.in_ready, 1);
    drive(d, a, r, left);
    push(d, a, r, left);
    @(negedge clock);
    bus.in_valid = 1'b0;
    collect(0, 1'b0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amount = '0;
    bus.in_rounds = '0;
    bus.out_ready = 1'b0;
`ifdef SPINNER_DIR_EN
    bus.in_left   = 1'b0;
`endif
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rdy", bus.in_ready, 1);

    send(8'h96, 1, 1, 1'b0);
    chk("k_4b", model(8'h96, 1, 1, 1'b0), 8'h4B);
    send(8'h96, 3, 2, 1'b0);
    send(8'h96, 3, 0, 1'b0);
    send(8'h96, 0, 15, 1'b0);
    for (int j = 0; j < 4; j++)
      send(W'($urandom), $urandom_range(0, W - 1),
           $urandom_range(0, 6), 1'b0);

    // backpressure with a competing offer held high through the handshake
    drive(8'h96, 5, 3, 1'b0);
    push(8'h96, 5, 3, 1'b0);
    @(negedge clock);
    bus.in_valid = 1'b0;
    collect(3, 1'b1);
    push(8'h3C, 1, 0, 1'b0);
    @(negedge clock);
    bus.in_valid = 1'b0;
    collect(0, 1'b0);

    // reset in the second busy cycle of a 5-round job
    drive(8'hA5, 1, 5, 1'b0);
    @(negedge clock);
    bus.in_valid = 1'b0;
    @(negedge clock);
    chk("mid_busy", bus.busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mr_valid", bus.out_valid, 0);
    chk("mr_data", bus.out_data, 0);
    chk("mr_rdy", bus.in_ready, 1);
    chk("mr_busy", bus.busy, 0);
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      chk("mr_quiet", bus.out_valid, 0);
    end

    send(8'h96, 1, 1, 1'b0);
`ifdef SPINNER_DIR_EN
    send(8'h96, 1, 1, 1'b1);
    chk("k_2d", model(8'h96, 1, 1, 1'b1), 8'h2D);
    send(8'h96, 3, 2, 1'b1);
    send(8'h96, 1, 1, 1'b0);
`endif
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
